// File: rtl/boreal_vec_sram_if.sv
// boreal_vec_sram_if: request/response bundle between the scratchpad SRAM
// responder and its three requesters (vector read, vector write, host MMIO).
//   rd_*    : vector read port (level req, one-cycle ack, held data)
//   wr_*    : vector write port (level req, one-cycle ack)
//   host_*  : host MMIO port (level sel, wr selects direction)
//   err     : sticky bad-address flag for vector accesses, err_clr clears it
// master = requester side, slave = SRAM responder side.
interface boreal_vec_sram_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        host_sel;
  logic        host_wr;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_ack;
  logic        err;
  logic        err_clr;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output host_sel, host_wr, host_addr, host_wdata, err_clr,
    input  rd_data, rd_ack, wr_ack, host_rdata, host_ack, err
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  host_sel, host_wr, host_addr, host_wdata, err_clr,
    output rd_data, rd_ack, wr_ack, host_rdata, host_ack, err
  );
endinterface

// File: rtl/boreal_vec_sram.sv
// boreal_vec_sram: single-port scratchpad shared by the vector read port,
// vector write port and host MMIO port through a round-robin arbiter with
// one access in flight.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : boreal_vec_sram_if.slave (all request/response signals)
// Parameters: DEPTH_LOG2 (2**DEPTH_LOG2 words of 32 bits),
//             WAIT_STATES (0..15 extra cycles between grant and access).
//
// state  | meaning
// IDLE   | arbitrate among pending requests, latch the winner
// WAIT   | burn WAIT_STATES cycles before touching the array
// ACCESS | perform read/write, raise the granted port's ack
// ACK    | ack high for this cycle only; requests ignored
module boreal_vec_sram #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 0
) (
  input logic               clk,
  input logic               rst_n,
  boreal_vec_sram_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK} state_t;

  localparam logic [1:0] P_RD   = 2'd0;
  localparam logic [1:0] P_WR   = 2'd1;
  localparam logic [1:0] P_HOST = 2'd2;

  logic [31:0] mem [2**DEPTH_LOG2];

  state_t                  state;
  logic [1:0]              last;
  logic [1:0]              cur_port;
  logic [DEPTH_LOG2-1:0]   cur_idx;
  logic [31:0]             cur_wdata;
  logic                    cur_bad;
  logic                    cur_write;
  logic [3:0]              wcnt;
  logic                    rd_ack_q, wr_ack_q, host_ack_q, err_q;
  logic [31:0]             rd_data_q, host_rdata_q;

  logic [2:0]              req_vec;
  logic [1:0]              c0, c1, c2, gnt;
  logic                    gnt_valid;
  logic [DEPTH_LOG2-1:0]   nxt_idx;
  logic [31:0]             nxt_wdata;
  logic                    nxt_bad, nxt_write;
  logic                    mem_we;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == P_HOST) ? P_RD : p + 2'd1;
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:DEPTH_LOG2+2] != '0);
  endfunction

  assign req_vec = {bus.host_sel, bus.wr_req, bus.rd_req};

  // Search starts one past the last granted port so every requester waits
  // for at most two other accesses.
  always_comb begin
    c0 = rr_next(last);
    c1 = rr_next(c0);
    c2 = rr_next(c1);
    gnt_valid = 1'b1;
    gnt = c0;
    if (req_vec[c0])      gnt = c0;
    else if (req_vec[c1]) gnt = c1;
    else if (req_vec[c2]) gnt = c2;
    else                  gnt_valid = 1'b0;
  end

  always_comb begin
    nxt_idx   = bus.host_addr[DEPTH_LOG2+1:2];
    nxt_wdata = bus.host_wdata;
    nxt_bad   = 1'b0;
    nxt_write = bus.host_wr;
    case (gnt)
      P_RD: begin
        nxt_idx   = bus.rd_addr[DEPTH_LOG2+1:2];
        nxt_bad   = addr_bad(bus.rd_addr);
        nxt_write = 1'b0;
      end
      P_WR: begin
        nxt_idx   = bus.wr_addr[DEPTH_LOG2+1:2];
        nxt_wdata = bus.wr_data;
        nxt_bad   = addr_bad(bus.wr_addr);
        nxt_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Gated by the FSM state, so an async reset before ACCESS suppresses it.
  assign mem_we = (state == S_ACCESS) && cur_write && !cur_bad;

  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_idx] <= cur_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      last         <= P_HOST;
      cur_port     <= P_RD;
      cur_idx      <= '0;
      cur_wdata    <= '0;
      cur_bad      <= 1'b0;
      cur_write    <= 1'b0;
      wcnt         <= '0;
      rd_ack_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      if (bus.err_clr) err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            last      <= gnt;
            cur_port  <= gnt;
            cur_idx   <= nxt_idx;
            cur_wdata <= nxt_wdata;
            cur_bad   <= nxt_bad;
            cur_write <= nxt_write;
            wcnt      <= 4'(WAIT_STATES);
            state     <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!cur_write) begin
            if (cur_port == P_HOST) host_rdata_q <= cur_bad ? 32'h0 : mem[cur_idx];
            else                    rd_data_q    <= cur_bad ? 32'h0 : mem[cur_idx];
          end
          case (cur_port)
            P_RD:    rd_ack_q   <= 1'b1;
            P_WR:    wr_ack_q   <= 1'b1;
            default: host_ack_q <= 1'b1;
          endcase
          // Placed after the err_clr clear so a coincident set wins.
          if (cur_bad) err_q <= 1'b1;
          state <= S_ACK;
        end
        S_ACK: begin
          rd_ack_q   <= 1'b0;
          wr_ack_q   <= 1'b0;
          host_ack_q <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_ack     = rd_ack_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.err        = err_q;

endmodule
